// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared widths, record layout and record builder for the commit trace path
package trace_pkg;

  localparam int TRACE_PC_W   = 32;
  localparam int TRACE_REG_W  = 5;
  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_CYC_W  = 32;
  localparam int TRACE_REC_W  = TRACE_PC_W + TRACE_REG_W + TRACE_DATA_W + TRACE_CYC_W;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic [TRACE_REG_W-1:0]  regidx;
    logic [TRACE_DATA_W-1:0] data;
    logic [TRACE_CYC_W-1:0]  cycle;
  } trace_rec_t;

  // Writes to $0 are architecturally discarded, so they are traced with value 0.
  function automatic trace_rec_t make_rec(
    input logic [TRACE_PC_W-1:0]   pc,
    input logic [TRACE_REG_W-1:0]  regidx,
    input logic [TRACE_DATA_W-1:0] data,
    input logic [TRACE_CYC_W-1:0]  cycle
  );
    trace_rec_t rec;
    rec.pc     = pc;
    rec.regidx = regidx;
    rec.data   = (regidx == '0) ? '0 : data;
    rec.cycle  = cycle;
    return rec;
  endfunction

endpackage

// File: rtl/commit_trace_fifo_if.sv
// rtl/commit_trace_fifo_if.sv - write-back tap and trace drain bundle
interface commit_trace_fifo_if;
  import trace_pkg::*;

  logic                    wb_en;
  logic [TRACE_PC_W-1:0]   wb_pc;
  logic [TRACE_REG_W-1:0]  wb_reg;
  logic [TRACE_DATA_W-1:0] wb_data;

  logic                    out_valid;
  logic                    out_ready;
  logic [TRACE_PC_W-1:0]   out_pc;
  logic [TRACE_REG_W-1:0]  out_reg;
  logic [TRACE_DATA_W-1:0] out_data;
  logic [TRACE_CYC_W-1:0]  out_cycle;

  // master: pipeline tap plus trace consumer; slave: the trace FIFO
  modport master (
    output wb_en, wb_pc, wb_reg, wb_data, out_ready,
    input  out_valid, out_pc, out_reg, out_data, out_cycle
  );

  modport slave (
    input  wb_en, wb_pc, wb_reg, wb_data, out_ready,
    output out_valid, out_pc, out_reg, out_data, out_cycle
  );

endinterface

// File: rtl/trace_fifo_mem.sv
// rtl/trace_fifo_mem.sv - trace record storage, synchronous write and asynchronous read
module trace_fifo_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [TRACE_REC_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [TRACE_REC_W-1:0] rdata
);

  logic [TRACE_REC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - timestamps write-back commits and buffers them for the trace drain
module commit_trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  commit_trace_fifo_if.slave       trace,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [TRACE_CYC_W-1:0] cycle_cnt;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   drop;
  trace_rec_t             wr_rec;
  trace_rec_t             head_rec;
  logic [TRACE_REC_W-1:0] rd_word;

  assign full            = (count == FULL_CNT);
  assign trace.out_valid = (count != '0);
  assign pop             = trace.out_valid & trace.out_ready;
  // A full FIFO still accepts a commit when the head leaves on the same edge.
  assign push            = trace.wb_en & (~full | pop);
  assign drop            = trace.wb_en & full & ~pop;

  assign wr_rec = make_rec(trace.wb_pc, trace.wb_reg, trace.wb_data, cycle_cnt);

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~reset),
    .waddr (wr_ptr),
    .wdata (wr_rec),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  assign head_rec = trace_rec_t'(rd_word);

  assign trace.out_pc    = trace.out_valid ? head_rec.pc     : '0;
  assign trace.out_reg   = trace.out_valid ? head_rec.regidx : '0;
  assign trace.out_data  = trace.out_valid ? head_rec.data   : '0;
  assign trace.out_cycle = trace.out_valid ? head_rec.cycle  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + TRACE_CYC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb/tb_commit_trace_fifo.sv - directed checks of commit_trace_fifo
module tb_commit_trace_fifo;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic [$clog2(DEPTH):0] count;
  logic overflow;
  logic [CNT_W-1:0] drop_cnt;

  commit_trace_fifo_if bus ();

  commit_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .trace    (bus),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [31:0] tcyc = 0;
  trace_rec_t exp_q[$];
  trace_rec_t e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic step();
    logic was_reset;
    was_reset = reset;
    @(posedge clk);
    #1;
    if (was_reset) tcyc = 0;
    else tcyc = tcyc + 1;
  endtask

  task automatic drive(input logic en, input logic [31:0] pc, input logic [4:0] rg, input logic [31:0] d);
    bus.wb_en   = en;
    bus.wb_pc   = pc;
    bus.wb_reg  = rg;
    bus.wb_data = d;
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 5'd1, 32'h2222_2222);
    step();
    step();

    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_reg", 32'(bus.out_reg), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_cycle", bus.out_cycle, 32'd0);

    // Test 1: first commit after reset is stamped 0
    reset = 1'b0;
    drive(1'b1, 32'h0000_3000, 5'd8, 32'h1234_5678);
    step();
    drive(1'b0, 32'h0, 5'd0, 32'h0);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_pc", bus.out_pc, 32'h0000_3000);
    chk("t1_reg", 32'(bus.out_reg), 32'd8);
    chk("t1_data", bus.out_data, 32'h1234_5678);
    chk("t1_cycle", bus.out_cycle, 32'd0);
    chk("t1_count", 32'(count), 32'd1);

    // Test 2: $0 commit traced with data 0
    drive(1'b1, 32'h0000_3004, 5'd0, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 32'h0, 5'd0, 32'h0);
    chk("t2_count", 32'(count), 32'd2);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t2_pc", bus.out_pc, 32'h0000_3004);
    chk("t2_reg", 32'(bus.out_reg), 32'd0);
    chk("t2_data", bus.out_data, 32'd0);
    chk("t2_cycle", bus.out_cycle, 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t2_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("t2_empty_data", bus.out_data, 32'd0);

    // Test 3: 18 commits into 16 entries with no drain
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 32'h0000_4000 + 32'(i * 4), 5'(i + 1), 32'hA000_0000 + 32'(i));
      if (i < 16) begin
        e.pc = 32'h0000_4000 + 32'(i * 4);
        e.regidx = 5'(i + 1);
        e.data = 32'hA000_0000 + 32'(i);
        e.cycle = tcyc;
        exp_q.push_back(e);
      end
      step();
    end
    drive(1'b0, 32'h0, 5'd0, 32'h0);
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_drop", 32'(drop_cnt), 32'd2);
    chk("t3_head_stable", bus.out_pc, 32'h0000_4000);

    // Test 4: push accepted on a full FIFO when the head pops on the same edge
    drive(1'b1, 32'h0000_5000, 5'd31, 32'h55AA_55AA);
    e.pc = 32'h0000_5000;
    e.regidx = 5'd31;
    e.data = 32'h55AA_55AA;
    e.cycle = tcyc;
    bus.out_ready = 1'b1;
    step();
    drive(1'b0, 32'h0, 5'd0, 32'h0);
    void'(exp_q.pop_front());
    exp_q.push_back(e);
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("t4_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("t4_pc_%0d", i), bus.out_pc, e.pc);
      chk($sformatf("t4_reg_%0d", i), 32'(bus.out_reg), 32'(e.regidx));
      chk($sformatf("t4_data_%0d", i), bus.out_data, e.data);
      chk($sformatf("t4_cycle_%0d", i), bus.out_cycle, e.cycle);
      step();
    end
    chk("t4_drained", 32'(count), 32'd0);

    // Test 5: steady push and pop from empty, pointers wrap several times
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 32'h0000_7000 + 32'(k * 4), 5'(k), 32'(k));
      step();
      chk($sformatf("t5_count_%0d", k), 32'(count), 32'd1);
      chk($sformatf("t5_cycle_%0d", k), bus.out_cycle, tcyc - 32'd1);
    end
    drive(1'b0, 32'h0, 5'd0, 32'h0);
    step();
    chk("t5_final_count", 32'(count), 32'd0);
    chk("t5_drop", 32'(drop_cnt), 32'd2);

    // Test 6: reset mid-drain discards entries and restarts the timestamp
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0000_8000 + 32'(i * 4), 5'd2, 32'(i));
      step();
    end
    drive(1'b0, 32'h0, 5'd0, 32'h0);
    bus.out_ready = 1'b1;
    step();
    step();
    chk("t6_mid_count", 32'(count), 32'd3);
    reset = 1'b1;
    drive(1'b1, 32'h0000_9999, 5'd4, 32'h9);
    step();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 32'h0);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    drive(1'b1, 32'h0000_6000, 5'd3, 32'd7);
    step();
    drive(1'b0, 32'h0, 5'd0, 32'h0);
    chk("t6_new_cycle", bus.out_cycle, 32'd0);
    chk("t6_new_pc", bus.out_pc, 32'h0000_6000);
    chk("t6_new_count", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
